// File: rtl/pipe_adder.sv
// ---------------------------------------------------------------------------
// pipe_adder
//   Pipelined add/subtract unit with a valid/ready handshake on both sides.
//   The WIDTH-bit carry chain is cut into STAGES equal slices.  Each stage adds
//   one slice and registers its carry.  The operand bits that are not yet
//   consumed travel forward with the partial sum.  The last stage produces the
//   result together with the zero/carry/overflow/negative flags, and these are
//   all registered in the same beat.
//
//   Parameters
//     WIDTH   operand/result width (8..64)
//     STAGES  pipeline depth == latency in cycles (1..4), WIDTH % STAGES == 0
//
//   Ports
//     clk        single clock, rising edge
//     rst_n      asynchronous active-low reset, clears all state
//     in_valid   operand set present
//     in_ready   operand set accepted when in_valid is also high
//     a_in,b_in  operands (WIDTH bits)
//     cin        carry-in (borrow-in when sub=1)
//     sub        0 = add, 1 = subtract (a - b - cin)
//     sat        saturation enable, sampled with the operands
//                (present only when PIPE_ADDER_SAT_EN is defined)
//     out_valid  result and flags valid
//     out_ready  consumer takes the result this cycle
//     O_out      result (WIDTH bits)
//     zero, carry, overflow, negative   result flags, forced to 0 on bubbles
//
//   Optional feature macro: PIPE_ADDER_SAT_EN adds the sat input, which
//   enables signed saturation.  The default build always wraps.
// ---------------------------------------------------------------------------
module pipe_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  input  logic             sub,
`ifdef PIPE_ADDER_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] O_out,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             negative
);

  localparam int SL = WIDTH / STAGES;               // bits per slice
  localparam int L  = STAGES - 1;                   // index of the output stage
  localparam int NI = (STAGES > 1) ? STAGES - 1 : 1; // intermediate register count

  if (WIDTH < 8 || WIDTH > 64 || STAGES < 1 || STAGES > 4 || (WIDTH % STAGES) != 0)
  begin : g_bad_param
    $error("pipe_adder: illegal WIDTH/STAGES combination");
  end

  // Signed overflow: both addends share a sign and the result sign differs.
  function automatic logic ovf_calc(input logic a_msb, input logic b_msb,
                                    input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

  // Clamp to the signed range limit on the side of the operand sign.
  function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] raw,
                                                input logic ovf,
                                                input logic sat_en,
                                                input logic a_msb);
    logic [WIDTH-1:0] lim;
    if (sat_en && ovf) begin
      lim = {WIDTH{1'b0}};
      if (a_msb) lim[WIDTH-1]   = 1'b1;             // 0x800..0
      else       lim[WIDTH-2:0] = {(WIDTH-1){1'b1}}; // 0x7FF..F
      return lim;
    end
    return raw;
  endfunction

  logic advance;
  logic sat_in;

`ifdef PIPE_ADDER_SAT_EN
  assign sat_in = sat;
`else
  assign sat_in = 1'b0;
`endif

  // Whole pipeline moves together; a stalled output freezes every stage.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Registers between stages k and k+1 (index k).
  logic [WIDTH-1:0] sum_p [NI];
  logic [WIDTH-1:0] a_p   [NI];
  logic [WIDTH-1:0] b_p   [NI];
  logic             c_p   [NI];
  logic             vld_p [NI];
  logic             sat_p [NI];

  // Inputs seen by each stage and what it produces.
  logic [WIDTH-1:0] a_src   [STAGES];
  logic [WIDTH-1:0] b_src   [STAGES];
  logic [WIDTH-1:0] sum_src [STAGES];
  logic             c_src   [STAGES];
  logic             vld_src [STAGES];
  logic             sat_src [STAGES];
  logic [WIDTH-1:0] sum_nxt [STAGES];
  logic             c_nxt   [STAGES];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SL:0]      slice_sum;
    logic [WIDTH-1:0] merged;

    if (k == 0) begin : g_first
      // Stage 0 sees the raw operands; subtraction is a + ~b + !cin.
      assign a_src[k]   = a_in;
      assign b_src[k]   = sub ? ~b_in : b_in;
      assign c_src[k]   = cin ^ sub;
      assign sum_src[k] = {WIDTH{1'b0}};
      assign vld_src[k] = in_valid;
      assign sat_src[k] = sat_in;
    end else begin : g_next
      assign a_src[k]   = a_p[k-1];
      assign b_src[k]   = b_p[k-1];
      assign c_src[k]   = c_p[k-1];
      assign sum_src[k] = sum_p[k-1];
      assign vld_src[k] = vld_p[k-1];
      assign sat_src[k] = sat_p[k-1];
    end

    assign slice_sum = {1'b0, a_src[k][k*SL +: SL]}
                     + {1'b0, b_src[k][k*SL +: SL]}
                     + {{SL{1'b0}}, c_src[k]};

    always_comb begin
      merged              = sum_src[k];
      merged[k*SL +: SL]  = slice_sum[SL-1:0];
    end

    assign sum_nxt[k] = merged;
    assign c_nxt[k]   = slice_sum[SL];
  end

  // ---- stage boundaries 0..STAGES-2: partial sum, carry, remaining operands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NI; k++) begin
        vld_p[k] <= 1'b0;
        sum_p[k] <= {WIDTH{1'b0}};
        a_p[k]   <= {WIDTH{1'b0}};
        b_p[k]   <= {WIDTH{1'b0}};
        c_p[k]   <= 1'b0;
        sat_p[k] <= 1'b0;
      end
    end else if (advance) begin
      for (int k = 0; k < STAGES - 1; k++) begin
        vld_p[k] <= vld_src[k];
        sum_p[k] <= sum_nxt[k];
        a_p[k]   <= a_src[k];
        b_p[k]   <= b_src[k];
        c_p[k]   <= c_nxt[k];
        sat_p[k] <= sat_src[k];
      end
    end
  end

  // Final slice result, overflow and optional clamp.
  logic [WIDTH-1:0] res_raw;
  logic [WIDTH-1:0] res_fin;
  logic             ovf_fin;

  assign res_raw = sum_nxt[L];
  assign ovf_fin = ovf_calc(a_src[L][WIDTH-1], b_src[L][WIDTH-1], res_raw[WIDTH-1]);
  assign res_fin = saturate(res_raw, ovf_fin, sat_src[L], a_src[L][WIDTH-1]);

  // ---- output stage: result and flags registered in the same beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      O_out     <= {WIDTH{1'b0}};
      zero      <= 1'b0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      negative  <= 1'b0;
    end else if (advance) begin
      out_valid <= vld_src[L];
      O_out     <= res_fin;
      // Flags are masked on bubbles so they are never shown without out_valid.
      zero      <= vld_src[L] && (res_fin == {WIDTH{1'b0}});
      carry     <= vld_src[L] && c_nxt[L];
      overflow  <= vld_src[L] && ovf_fin;
      negative  <= vld_src[L] && res_fin[WIDTH-1];
    end
  end

endmodule

// File: tb/tb_pipe_adder.sv
module tb_pipe_adder;
  localparam int WIDTH  = 32;
  localparam int STAGES = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  a_in;
  logic [WIDTH-1:0]  b_in;
  logic              cin;
  logic              sub;
  logic              sat_i;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  O_out;
  logic              zero;
  logic              carry;
  logic              overflow;
  logic              negative;

  always #5 clk = ~clk;

  pipe_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .cin       (cin),
    .sub       (sub),
`ifdef PIPE_ADDER_SAT_EN
    .sat       (sat_i),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .O_out     (O_out),
    .zero      (zero),
    .carry     (carry),
    .overflow  (overflow),
    .negative  (negative)
  );

  typedef struct packed {
    logic [31:0] o;
    logic        c;
    logic        v;
    logic        z;
    logic        n;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic        s;
    res_t        exp;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   taken  = 0;
  logic accepted;
  logic held = 1'b0;
  res_t held_val;
  res_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Reference: whole-word arithmetic straight from the add/sub rules.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic ci, input logic s, input logic st);
    logic [31:0] be;
    logic [32:0] t;
    res_t        r;
    be  = s ? ~b : b;
    t   = {1'b0, a} + {1'b0, be} + {32'd0, ci ^ s};
    r.o = t[31:0];
    r.c = t[32];
    r.v = (a[31] == be[31]) && (r.o[31] != a[31]);
    if (st && r.v) r.o = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    r.z = (r.o == 32'd0);
    r.n = r.o[31];
    return r;
  endfunction

  function automatic res_t cur_out();
    res_t r;
    r.o = O_out; r.c = carry; r.v = overflow; r.z = zero; r.n = negative;
    return r;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  // One clock of handshake traffic, checked against the scoreboard.
  task automatic step(input logic iv, input logic [31:0] a, input logic [31:0] b,
                      input logic ci, input logic s, input logic st, input logic ordy);
    logic st_eff;
`ifdef PIPE_ADDER_SAT_EN
    st_eff = st;
`else
    st_eff = 1'b0;
`endif
    @(negedge clk);
    in_valid  = iv;
    a_in      = a;
    b_in      = b;
    cin       = ci;
    sub       = s;
    sat_i     = st_eff;
    out_ready = ordy;
    #1;
    if (held) begin
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_data", 64'(cur_out()), 64'(held_val));
    end
    check("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
    held = out_valid && !out_ready;
    if (held) held_val = cur_out();
    if (!out_valid)
      check("bubble_flags", 64'({zero, carry, overflow, negative}), 64'd0);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %0h, required no result", O_out);
      end else begin
        check("result", 64'(cur_out()), 64'(exp_q.pop_front()));
        taken++;
      end
    end
    accepted = iv && in_ready;
    if (accepted) exp_q.push_back(model(a, b, ci, s, st_eff));
  endtask

  task automatic drain(input int budget);
    for (int n = 0; n < budget && exp_q.size() > 0; n++)
      step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[8];
    logic [31:0] sa [4];
    logic [31:0] sb [4];
    int          idx;
    int          t0;

    vecs[0] = '{32'h8000_0000, 32'h8000_0001, 1'b1, 1'b0, '{32'h0000_0002, 1'b1, 1'b1, 1'b0, 1'b0}};
    vecs[1] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, '{32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0}};
    vecs[2] = '{32'h0000_0000, 32'h8000_0001, 1'b0, 1'b0, '{32'h8000_0001, 1'b0, 1'b0, 1'b0, 1'b1}};
    vecs[3] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, '{32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1}};
    vecs[4] = '{32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, '{32'h0000_0002, 1'b1, 1'b0, 1'b0, 1'b0}};
    vecs[5] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, '{32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1}};
    vecs[6] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, '{32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1}};
    vecs[7] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, '{32'h0001_0000, 1'b0, 1'b0, 1'b0, 1'b0}};

    sa = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h1234_5678, 32'h7FFF_FFFF};
    sb = '{32'h0000_0002, 32'h0000_0001, 32'h1111_1111, 32'h7FFF_FFFF};

    rst_n = 1'b0; in_valid = 1'b0; a_in = '0; b_in = '0; cin = 1'b0; sub = 1'b0;
    sat_i = 1'b0; out_ready = 1'b0;

    // Reset state
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_O_out", 64'(O_out), 64'd0);
    check("rst_flags", 64'({zero, carry, overflow, negative}), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors, one at a time, with exact latency check
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a_in = vecs[i].a; b_in = vecs[i].b;
      cin = vecs[i].ci; sub = vecs[i].s; out_ready = 1'b1;
      for (int j = 0; j < STAGES; j++) begin
        @(negedge clk);
        if (j == 0) in_valid = 1'b0;
        if (j < STAGES - 1) check($sformatf("vec%0d_early", i), 64'(out_valid), 64'd0);
      end
      check($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
      check($sformatf("vec%0d_out", i), 64'(cur_out()), 64'(vecs[i].exp));
    end
    @(negedge clk);

    // Back-pressure: 4 beats offered while the consumer stalls for 5 cycles
    idx = 0;
    t0  = taken;
    for (int cyc = 0; cyc < 5; cyc++) begin
      step(idx < 4, sa[idx % 4], sb[idx % 4], 1'b0, 1'b0, 1'b0, 1'b0);
      if (accepted) idx++;
      if (cyc == 4) begin
        check("stall_in_ready", 64'(in_ready), 64'd0);
        check("stall_out_valid", 64'(out_valid), 64'd1);
        check("stall_accepted", 64'(idx), 64'(STAGES));
      end
    end
    for (int n = 0; n < 40 && (idx < 4 || exp_q.size() > 0); n++) begin
      step(idx < 4, sa[idx % 4], sb[idx % 4], 1'b0, 1'b0, 1'b0, 1'b1);
      if (accepted) idx++;
    end
    check("stall_delivered", 64'(taken - t0), 64'd4);

    // Randomized traffic with random stalls
    for (int n = 0; n < 600; n++)
      step($urandom_range(0, 3) != 0, pick(), pick(), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
    drain(40);

    // Asynchronous reset with two beats in flight
    step(1'b1, 32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0000_0030, 32'h0000_0040, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_O_out", 64'(O_out), 64'd0);
    check("midrst_flags", 64'({zero, carry, overflow, negative}), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    exp_q.delete();
    held = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 4; n++)
      step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    t0 = taken;
    step(1'b1, 32'h0000_0100, 32'h0000_0023, 1'b0, 1'b0, 1'b0, 1'b1);
    drain(10);
    check("postrst_first_beat", 64'(taken - t0), 64'd1);

`ifdef PIPE_ADDER_SAT_EN
    // Saturation corners
    @(negedge clk);
    in_valid = 1'b1; a_in = 32'h7FFF_FFFF; b_in = 32'h0000_0001; cin = 1'b0;
    sub = 1'b0; sat_i = 1'b1; out_ready = 1'b1;
    for (int j = 0; j < STAGES; j++) begin
      @(negedge clk);
      if (j == 0) in_valid = 1'b0;
    end
    check("sat_max_out", 64'(O_out), 64'h7FFF_FFFF);
    check("sat_max_ovf", 64'(overflow), 64'd1);
    check("sat_max_neg", 64'(negative), 64'd0);
    step(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b1, 1'b1);
    drain(10);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand/result width; legal values 8..64.
REQ-002 SHALL have parameter STAGES, default 2: pipeline depth; legal values 1..4; WIDTH divisible by STAGES.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: operand set present.
REQ-006 SHALL have port in_ready, output, 1 bit: operand set accepted this cycle when in_valid is also high.
REQ-007 SHALL have ports a_in and b_in, input, WIDTH bits each: operands.
REQ-008 SHALL have port cin, input, 1 bit: carry-in (borrow-in when sub=1).
REQ-009 SHALL have port sub, input, 1 bit: 0 = add, 1 = subtract.
REQ-010 SHALL have port out_valid, output, 1 bit: result and flags valid.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer takes the result this cycle.
REQ-012 SHALL have port O_out, output, WIDTH bits: result.
REQ-013 SHALL have ports zero, carry, overflow and negative, output, 1 bit each: result flags.

Function
REQ-014 SHALL compute b_eff = sub ? ~b_in : b_in, c_eff = cin ^ sub, and O_out = a_in + b_eff + c_eff mod 2^WIDTH; sub=1 therefore gives a_in - b_in - cin.
REQ-015 SHALL split the carry chain into STAGES slices of WIDTH/STAGES bits, one slice per stage, with the slice carry registered between stages and unprocessed operand bits carried forward.
REQ-016 SHALL set carry to the raw carry-out of the MSB slice (no borrow inversion).
REQ-017 SHALL set overflow to (a[MSB] == b_eff[MSB]) && (O_out[MSB] != a[MSB]).
REQ-018 SHALL set negative = O_out[MSB] and zero = (O_out == 0); all flags SHALL be registered with O_out in the same beat.
REQ-019 SHALL produce latency of exactly STAGES cycles from an accepted input to out_valid when not stalled, with throughput of one result per cycle.
REQ-020 SHALL use advance = !out_valid || out_ready and in_ready = advance; every stage register, including its valid bit, moves only when advance is high.
REQ-021 SHALL hold O_out, all flags and out_valid stable while out_valid=1 and out_ready=0.
REQ-022 SHALL propagate bubbles (valid=0) when in_valid=0 during advance; bubble data SHALL be don't-care but flags SHALL NOT be presented unless out_valid=1.
REQ-023 SHALL, on simultaneous output take and input accept, accept the new input and move the pipeline in the same cycle with no lost or duplicated beats.
REQ-024 SHALL ignore a_in, b_in, cin and sub when in_valid=0 or in_ready=0.

Reset
REQ-025 SHALL clear every stage valid bit, every data/carry register, O_out and all four flags to 0 immediately on rst_n=0, independent of clk.
REQ-026 SHALL drive in_ready=1 while rst_n=0 is deasserted-pending and SHALL discard all in-flight beats on a reset mid-operation; the first beat after release is the first beat accepted after release.

Configuration
REQ-027 SHALL, with macro PIPE_ADDER_SAT_EN defined, add input port sat (1 bit, sampled with the operands): when sat=1 and overflow=1, O_out clamps to the signed max (0x7FF..F) if a[MSB]=0, else to the signed min (0x800..0); the overflow flag stays 1; zero and negative follow the clamped value.
REQ-028 SHALL, without PIPE_ADDER_SAT_EN, omit the sat port and always wrap per REQ-014.

Verification (WIDTH=32, STAGES=2)
REQ-029 SHALL cover a_in=0x80000000, b_in=0x80000001, cin=1, sub=0 -> 2 cycles later O_out=0x00000002, carry=1, overflow=1, zero=0, negative=0.
REQ-030 SHALL cover a_in=0, b_in=0, cin=0 -> O_out=0, zero=1, carry=0, overflow=0, negative=0; and a_in=0, b_in=0x80000001, cin=0 -> O_out=0x80000001, negative=1, overflow=0.
REQ-031 SHALL cover sub=1, a_in=5, b_in=7, cin=0 -> O_out=0xFFFFFFFE, carry=0, negative=1, overflow=0; and a_in=7, b_in=5 -> O_out=2, carry=1.
REQ-032 SHALL cover 4 back-to-back beats with out_ready held 0 for 5 cycles -> in_ready=0 once the pipe is full, first result held stable, all 4 results delivered in order after release.
REQ-033 SHALL cover rst_n pulsed low with 2 beats in flight -> out_valid=0 and O_out=0 immediately, and no stale result after release.
REQ-034 SHALL cover, with PIPE_ADDER_SAT_EN, sat=1, a_in=0x7FFFFFFF, b_in=1 -> O_out=0x7FFFFFFF, overflow=1.
